inst_mem_loader: RTL and testbench

Core-side responder for the instruction load interface that the bench drives (iInst2Write/iInstWen, then iStart). It accepts a stream of 32-bit instruction words and stores them at auto-incremented word addresses in an internal instruction RAM. On iStart it switches to run mode, where it serves fetch-stage read requests with a registered, one-cycle-latency response. It sits inside Top, between the external load pins and the fetch stage.

---
 rtl/inst_mem_loader_pkg.sv | 33 +++
 rtl/inst_mem_loader_ram.sv | 42 ++++
 rtl/inst_mem_loader.sv | 152 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
//   cXLEN       instruction / data width
//   cNopInst    word returned for a rejected fetch (addi x0,x0,0)
//   tLoaderState  LOAD (accepting words) / RUN (serving fetches)
//   tFetchRsp   fetch response bundle {instr, vld, err}
//   tRspSrc     which source drives the held fetch data output
package inst_mem_loader_pkg;

   localparam int cXLEN = 32;
   localparam logic [cXLEN-1:0] cNopInst = 32'h0000_0013;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } tLoaderState;

   typedef struct packed {
      logic [cXLEN-1:0] instr;
      logic             vld;
      logic             err;
   } tFetchRsp;

   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_NOP  = 2'd1,
      SRC_RAM  = 2'd2
   } tRspSrc;

   function automatic logic pc_misaligned(input logic [cXLEN-1:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/inst_mem_loader_ram.sv
// inst_ram: simple dual-port synchronous RAM, cDepth x cWidth.
//   iClk    clock
//   iWen    write enable, iWaddr/iWdata written on the rising edge
//   iRen    read enable, oRdata updated one edge later, held otherwise
//   iRaddr  read word address
//   oRdata  registered read data
// No reset on storage or read data so it maps onto a vendor RAM macro.
module inst_ram #(
   parameter int cDepth = 256,
   parameter int cWidth = 32,
   localparam int cAw   = $clog2(cDepth)
) (
   input  logic              iClk,
   input  logic              iWen,
   input  logic [cAw-1:0]    iWaddr,
   input  logic [cWidth-1:0] iWdata,
   input  logic              iRen,
   input  logic [cAw-1:0]    iRaddr,
   output logic [cWidth-1:0] oRdata
);

   logic [cWidth-1:0] mem_q [cDepth];
   logic [cWidth-1:0] rdata_d;
   logic [cWidth-1:0] rdata_q;

   always_comb begin
      rdata_d = rdata_q;
      if (iRen) begin
         rdata_d = mem_q[iRaddr];
      end
   end

   always_ff @(posedge iClk) begin
      if (iWen) begin
         mem_q[iWaddr] <= iWdata;
      end
      rdata_q <= rdata_d;
   end

   assign oRdata = rdata_q;

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a stream of instruction words into an internal RAM,
// then serves fetch requests with a one-cycle registered response.
//   iClk, iRstN       clock, asynchronous active-low reset
//   iInst2Write/iInstWen  word to store / write strobe (LOAD only)
//   iStart            level, moves LOAD -> RUN
//   iFetchReq/iFetchPc    fetch request and byte PC (RUN only)
//   oFetchInstr/oFetchVld/oFetchErr  fetch response, data held between pulses
//   oLoadCount        words stored; oRunning state == RUN
//   oOverflow         sticky, write attempted with RAM full
//   oLateWrite        sticky, write strobe seen in RUN
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int cDepth = 256
) (
   input  logic                     iClk,
   input  logic                     iRstN,
   input  logic [cXLEN-1:0]         iInst2Write,
   input  logic                     iInstWen,
   input  logic                     iStart,
   input  logic                     iFetchReq,
   input  logic [cXLEN-1:0]         iFetchPc,
   output logic [cXLEN-1:0]         oFetchInstr,
   output logic                     oFetchVld,
   output logic                     oFetchErr,
   output logic [$clog2(cDepth):0]  oLoadCount,
   output logic                     oRunning,
   output logic                     oOverflow,
   output logic                     oLateWrite
);

   localparam int cAw = $clog2(cDepth);

   tLoaderState      state_q, state_d;
   logic [cAw:0]     count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             late_q, late_d;
   logic             vld_q, vld_d;
   logic             err_q, err_d;
   tRspSrc           src_q, src_d;

   logic             ram_wen;
   logic             ram_ren;
   logic [cXLEN-1:0] ram_rdata;
   logic [cXLEN-1:0] count_ext;
   logic             pc_bad;
   tFetchRsp         rsp;

   // The count doubles as the write pointer; its MSB set means the RAM is full.
   assign count_ext = {{(cXLEN-cAw-1){1'b0}}, count_q};

   // Full upper PC bits take part, so PCs beyond the RAM are always rejected.
   assign pc_bad = pc_misaligned(iFetchPc) ||
                   ({2'b00, iFetchPc[cXLEN-1:2]} >= count_ext);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      late_d     = late_q;
      vld_d      = 1'b0;
      err_d      = 1'b0;
      src_d      = src_q;
      ram_wen    = 1'b0;
      ram_ren    = 1'b0;
      case (state_q)
         LOAD: begin
            if (iInstWen) begin
               if (count_q[cAw]) begin
                  overflow_d = 1'b1;
               end else begin
                  ram_wen = 1'b1;
                  count_d = count_q + 1'b1;
               end
            end
            if (iStart) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (iInstWen) begin
               late_d = 1'b1;
            end
            if (iFetchReq) begin
               vld_d = 1'b1;
               if (pc_bad) begin
                  err_d = 1'b1;
                  src_d = SRC_NOP;
               end else begin
                  ram_ren = 1'b1;
                  src_d   = SRC_RAM;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q    <= LOAD;
         count_q    <= '0;
         overflow_q <= 1'b0;
         late_q     <= 1'b0;
         vld_q      <= 1'b0;
         err_q      <= 1'b0;
         src_q      <= SRC_ZERO;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         late_q     <= late_d;
         vld_q      <= vld_d;
         err_q      <= err_d;
         src_q      <= src_d;
      end
   end

   inst_ram #(
      .cDepth (cDepth),
      .cWidth (cXLEN)
   ) u_inst_ram (
      .iClk   (iClk),
      .iWen   (ram_wen),
      .iWaddr (count_q[cAw-1:0]),
      .iWdata (iInst2Write),
      .iRen   (ram_ren),
      .iRaddr (iFetchPc[cAw+1:2]),
      .oRdata (ram_rdata)
   );

   // The RAM read register only moves on accepted fetches, so selecting it
   // by the held source keeps oFetchInstr stable between responses.
   always_comb begin
      rsp.vld = vld_q;
      rsp.err = err_q;
      case (src_q)
         SRC_RAM: rsp.instr = ram_rdata;
         SRC_NOP: rsp.instr = cNopInst;
         default: rsp.instr = '0;
      endcase
   end

   assign oFetchInstr = rsp.instr;
   assign oFetchVld   = rsp.vld;
   assign oFetchErr   = rsp.err;
   assign oLoadCount  = count_q;
   assign oRunning    = (state_q == RUN);
   assign oOverflow   = overflow_q;
   assign oLateWrite  = late_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: two instances (depth 256 and depth 4) share all
// inputs; a behavioural model tracks both and is compared every cycle, and
// directed literal checks pin the model.
module tb_inst_mem_loader;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] wdata = '0;
   logic        wen = 1'b0;
   logic        start = 1'b0;
   logic        req = 1'b0;
   logic [31:0] pc = '0;

   logic [31:0] o_instr [2];
   logic        o_vld [2];
   logic        o_err [2];
   logic        o_run [2];
   logic        o_ovf [2];
   logic        o_late [2];
   logic [8:0]  cnt0;
   logic [2:0]  cnt4;

   int n_pass = 0;
   int n_tot  = 0;

   inst_mem_loader #(.cDepth(256)) dut (
      .iClk(clk), .iRstN(rstn), .iInst2Write(wdata), .iInstWen(wen),
      .iStart(start), .iFetchReq(req), .iFetchPc(pc),
      .oFetchInstr(o_instr[0]), .oFetchVld(o_vld[0]), .oFetchErr(o_err[0]),
      .oLoadCount(cnt0), .oRunning(o_run[0]), .oOverflow(o_ovf[0]),
      .oLateWrite(o_late[0])
   );

   inst_mem_loader #(.cDepth(4)) dut4 (
      .iClk(clk), .iRstN(rstn), .iInst2Write(wdata), .iInstWen(wen),
      .iStart(start), .iFetchReq(req), .iFetchPc(pc),
      .oFetchInstr(o_instr[1]), .oFetchVld(o_vld[1]), .oFetchErr(o_err[1]),
      .oLoadCount(cnt4), .oRunning(o_run[1]), .oOverflow(o_ovf[1]),
      .oLateWrite(o_late[1])
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int          depth [2] = '{256, 4};
   int          m_cnt [2];
   bit          m_run [2], m_ovf [2], m_late [2], m_vld [2], m_err [2];
   logic [31:0] m_instr [2];
   logic [31:0] m_mem [2][256];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_run[k] = 0; m_ovf[k] = 0; m_late[k] = 0;
         m_vld[k] = 0; m_err[k] = 0; m_instr[k] = '0;
      end
   endtask

   task automatic model_step();
      logic [31:0] idx;
      for (int k = 0; k < 2; k++) begin
         m_vld[k] = m_run[k] && req;
         m_err[k] = 0;
         if (m_vld[k]) begin
            idx = pc >> 2;
            if (pc % 4 != 0 || idx >= 32'(m_cnt[k])) begin
               m_err[k] = 1; m_instr[k] = NOP;
            end else begin
               m_instr[k] = m_mem[k][idx];
            end
         end
         if (!m_run[k]) begin
            if (wen) begin
               if (m_cnt[k] < depth[k]) begin
                  m_mem[k][m_cnt[k]] = wdata;
                  m_cnt[k]++;
               end else m_ovf[k] = 1;
            end
            if (start) m_run[k] = 1;
         end else if (wen) m_late[k] = 1;
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("d%0d_count", k), k == 0 ? 32'(cnt0) : 32'(cnt4), 32'(m_cnt[k]));
         check($sformatf("d%0d_running", k), 32'(o_run[k]), 32'(m_run[k]));
         check($sformatf("d%0d_overflow", k), 32'(o_ovf[k]), 32'(m_ovf[k]));
         check($sformatf("d%0d_latewrite", k), 32'(o_late[k]), 32'(m_late[k]));
         check($sformatf("d%0d_vld", k), 32'(o_vld[k]), 32'(m_vld[k]));
         check($sformatf("d%0d_instr", k), o_instr[k], m_instr[k]);
         if (m_vld[k]) check($sformatf("d%0d_err", k), 32'(o_err[k]), 32'(m_err[k]));
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) model_reset();
         else model_step();
         #1;
         compare_all();
      end
   end

   // ---------------- directed stimulus ----------------
   function automatic logic [31:0] word(input int i);
      return ((i + 1) << 20) | 32'h93;
   endfunction

   task automatic do_reset();
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      check("reset_count", 32'(cnt0), 0);
      check("reset_running", 32'(o_run[0]), 0);

      // fetch during LOAD is ignored
      req = 1'b1; pc = 0;
      @(negedge clk);
      req = 1'b0;
      check("load_fetch_vld", 32'(o_vld[0]), 0);

      // 10 words: fills dut, overflows dut4
      for (int i = 0; i < 10; i++) begin
         wen = 1'b1; wdata = word(i);
         @(negedge clk);
      end
      wen = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("load10_count", 32'(cnt0), 10);
      check("load10_running", 32'(o_run[0]), 1);
      check("dut4_count", 32'(cnt4), 4);
      check("dut4_overflow", 32'(o_ovf[1]), 1);
      check("dut256_no_overflow", 32'(o_ovf[0]), 0);

      // back-to-back fetches
      for (int i = 0; i < 10; i++) begin
         req = 1'b1; pc = 32'(4 * i);
         @(negedge clk);
         check($sformatf("fetch_pc%0d_instr", 4 * i), o_instr[0], word(i));
         check($sformatf("fetch_pc%0d_vld", 4 * i), 32'(o_vld[0]), 1);
         check($sformatf("fetch_pc%0d_err", 4 * i), 32'(o_err[0]), 0);
      end
      pc = 40;
      @(negedge clk);
      check("oob_pc40_instr", o_instr[0], NOP);
      check("oob_pc40_err", 32'(o_err[0]), 1);
      pc = 32'h2;
      @(negedge clk);
      check("misaligned_vld", 32'(o_vld[0]), 1);
      check("misaligned_err", 32'(o_err[0]), 1);
      check("misaligned_instr", o_instr[0], NOP);
      pc = 12;
      @(negedge clk);
      check("dut4_pc12_instr", o_instr[1], 32'h0040_0093);
      check("dut4_pc12_err", 32'(o_err[1]), 0);
      req = 1'b0;
      @(negedge clk);
      check("idle_vld", 32'(o_vld[0]), 0);
      check("idle_hold", o_instr[0], 32'h0040_0093);

      // write strobe in RUN
      wen = 1'b1; wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      wen = 1'b0;
      check("late_write", 32'(o_late[0]), 1);
      req = 1'b1; pc = 0;
      @(negedge clk);
      req = 1'b0;
      check("late_ram_unchanged", o_instr[0], 32'h0010_0093);

      // asynchronous reset between edges
      #2 rstn = 1'b0;
      #1;
      check("async_vld", 32'(o_vld[0]), 0);
      check("async_count", 32'(cnt0), 0);
      check("async_running", 32'(o_run[0]), 0);
      check("async_late", 32'(o_late[0]), 0);
      check("async_instr", o_instr[0], 0);
      check("async_ovf4", 32'(o_ovf[1]), 0);
      @(negedge clk);
      rstn = 1'b1;

      // reload 2 words; stale RAM at index 2 must stay unreachable
      wen = 1'b1; wdata = 32'h1111_1111;
      @(negedge clk);
      wdata = 32'h2222_2222;
      @(negedge clk);
      wen = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      req = 1'b1; pc = 8;
      @(negedge clk);
      check("reload_pc8_err", 32'(o_err[0]), 1);
      check("reload_pc8_instr", o_instr[0], NOP);
      pc = 4;
      @(negedge clk);
      req = 1'b0;
      check("reload_pc4_instr", o_instr[0], 32'h2222_2222);

      // zero words then start, start held high
      do_reset();
      start = 1'b1;
      @(negedge clk);
      req = 1'b1; pc = 0;
      @(negedge clk);
      req = 1'b0;
      check("empty_running", 32'(o_run[0]), 1);
      check("empty_err", 32'(o_err[0]), 1);
      check("empty_instr", o_instr[0], NOP);
      @(negedge clk);
      start = 1'b0;

      // write together with start on the 3rd word
      do_reset();
      wen = 1'b1; wdata = 32'hA000_0001;
      @(negedge clk);
      wdata = 32'hA000_0002;
      @(negedge clk);
      wdata = 32'hA000_0003; start = 1'b1;
      @(negedge clk);
      wen = 1'b0; start = 1'b0;
      check("wen_start_count", 32'(cnt0), 3);
      check("wen_start_running", 32'(o_run[0]), 1);
      wen = 1'b1; wdata = 32'hBAD0_BAD0;
      @(negedge clk);
      wen = 1'b0;
      check("wen_start_late", 32'(o_late[0]), 1);
      check("wen_start_count_kept", 32'(cnt0), 3);
      req = 1'b1; pc = 8;
      @(negedge clk);
      check("wen_start_pc8", o_instr[0], 32'hA000_0003);
      pc = 12;
      @(negedge clk);
      req = 1'b0;
      check("wen_start_pc12_err", 32'(o_err[0]), 1);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
